// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter
//   Shares one pipelined bitwise ALU between requesters A and B. Grants the
//   ALU input side round-robin, records the issuer of every operation in a
//   tag FIFO and steers each returning result/overflow bundle back to that
//   issuer. Illegal opcodes are consumed without touching the ALU; results
//   that arrive with no tag outstanding are accepted and dropped.
//
// Ports (each stream is a valid/data/ack triple; transfer = valid && ack)
//   clock, reset                   rising-edge clock, async active-high reset
//   {a,b}_operator/left/right      requester inputs (consumed here)
//   {a,b}_result/overflow          requester outputs
//   alu_operator/left/right        towards the ALU inputs
//   alu_result/overflow            from the ALU outputs
//   illegal_op                     1-cycle pulse: illegal operator discarded
//   stray_result                   1-cycle pulse: untagged result dropped
module alu_request_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int LAST_OPCODE  = 6,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_operator_valid,
  input  logic [DATA_WIDTH-1:0] a_operator_data,
  output logic                  a_operator_ack,
  input  logic                  a_left_valid,
  input  logic [DATA_WIDTH-1:0] a_left_data,
  output logic                  a_left_ack,
  input  logic                  a_right_valid,
  input  logic [DATA_WIDTH-1:0] a_right_data,
  output logic                  a_right_ack,
  output logic                  a_result_valid,
  output logic [DATA_WIDTH-1:0] a_result_data,
  input  logic                  a_result_ack,
  output logic                  a_overflow_valid,
  output logic [DATA_WIDTH-1:0] a_overflow_data,
  input  logic                  a_overflow_ack,
  input  logic                  b_operator_valid,
  input  logic [DATA_WIDTH-1:0] b_operator_data,
  output logic                  b_operator_ack,
  input  logic                  b_left_valid,
  input  logic [DATA_WIDTH-1:0] b_left_data,
  output logic                  b_left_ack,
  input  logic                  b_right_valid,
  input  logic [DATA_WIDTH-1:0] b_right_data,
  output logic                  b_right_ack,
  output logic                  b_result_valid,
  output logic [DATA_WIDTH-1:0] b_result_data,
  input  logic                  b_result_ack,
  output logic                  b_overflow_valid,
  output logic [DATA_WIDTH-1:0] b_overflow_data,
  input  logic                  b_overflow_ack,
  output logic                  alu_operator_valid,
  output logic [DATA_WIDTH-1:0] alu_operator_data,
  input  logic                  alu_operator_ack,
  output logic                  alu_left_valid,
  output logic [DATA_WIDTH-1:0] alu_left_data,
  input  logic                  alu_left_ack,
  output logic                  alu_right_valid,
  output logic [DATA_WIDTH-1:0] alu_right_data,
  input  logic                  alu_right_ack,
  input  logic                  alu_result_valid,
  input  logic [DATA_WIDTH-1:0] alu_result_data,
  output logic                  alu_result_ack,
  input  logic                  alu_overflow_valid,
  input  logic [DATA_WIDTH-1:0] alu_overflow_data,
  output logic                  alu_overflow_ack,
  output logic                  illegal_op,
  output logic                  stray_result
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

  req_e                 last_served;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                  full;
  logic                  has_tag;
  logic                  grant;
  logic                  illegal;
  logic                  issue;
  logic                  pop;
  logic                  bundle_valid;
  logic                  sel_result_ack;
  logic                  sel_overflow_ack;
  req_e                  gnt_id;
  req_e                  tag;
  logic [DATA_WIDTH-1:0] op_data;

  // Full is taken from the registered count, so a pop in the same cycle
  // does not reopen the grant.
  assign full    = (count == CNT_W'(TAG_DEPTH));
  assign has_tag = (count != '0);
  assign tag     = req_e'(tag_mem[rd_ptr]);

  always_comb begin
    grant  = 1'b0;
    gnt_id = REQ_A;
    if (!full) begin
      if (a_operator_valid && b_operator_valid) begin
        grant  = 1'b1;
        gnt_id = (last_served == REQ_A) ? REQ_B : REQ_A;
      end else if (a_operator_valid) begin
        grant  = 1'b1;
        gnt_id = REQ_A;
      end else if (b_operator_valid) begin
        grant  = 1'b1;
        gnt_id = REQ_B;
      end
    end
  end

  assign op_data = (gnt_id == REQ_B) ? b_operator_data : a_operator_data;
  assign illegal = grant && (op_data[OPCODE_WIDTH-1:0] > OPCODE_WIDTH'(LAST_OPCODE));

  always_comb begin
    alu_operator_data  = op_data;
    alu_left_data      = (gnt_id == REQ_B) ? b_left_data  : a_left_data;
    alu_right_data     = (gnt_id == REQ_B) ? b_right_data : a_right_data;
    alu_operator_valid = 1'b0;
    alu_left_valid     = 1'b0;
    alu_right_valid    = 1'b0;
    a_operator_ack     = 1'b0;
    a_left_ack         = 1'b0;
    a_right_ack        = 1'b0;
    b_operator_ack     = 1'b0;
    b_left_ack         = 1'b0;
    b_right_ack        = 1'b0;
    if (illegal) begin
      // Swallow only the operator; the operands stay queued for the next op.
      if (gnt_id == REQ_B) b_operator_ack = 1'b1;
      else                 a_operator_ack = 1'b1;
    end else if (grant) begin
      alu_operator_valid = 1'b1;
      if (gnt_id == REQ_B) begin
        alu_left_valid  = b_left_valid;
        alu_right_valid = b_right_valid;
        b_operator_ack  = alu_operator_ack;
        b_left_ack      = alu_left_ack;
        b_right_ack     = alu_right_ack;
      end else begin
        alu_left_valid  = a_left_valid;
        alu_right_valid = a_right_valid;
        a_operator_ack  = alu_operator_ack;
        a_left_ack      = alu_left_ack;
        a_right_ack     = alu_right_ack;
      end
    end
  end

  assign issue = grant && !illegal && alu_operator_ack;

  assign bundle_valid     = alu_result_valid || alu_overflow_valid;
  assign a_result_valid   = alu_result_valid   && has_tag && (tag == REQ_A);
  assign b_result_valid   = alu_result_valid   && has_tag && (tag == REQ_B);
  assign a_overflow_valid = alu_overflow_valid && has_tag && (tag == REQ_A);
  assign b_overflow_valid = alu_overflow_valid && has_tag && (tag == REQ_B);
  assign a_result_data    = alu_result_data;
  assign b_result_data    = alu_result_data;
  assign a_overflow_data  = alu_overflow_data;
  assign b_overflow_data  = alu_overflow_data;

  assign sel_result_ack   = (tag == REQ_B) ? b_result_ack   : a_result_ack;
  assign sel_overflow_ack = (tag == REQ_B) ? b_overflow_ack : a_overflow_ack;

  // Each half is acked only when the other valid half is acked too, so the
  // ALU always sees a bundle leave as a whole.
  always_comb begin
    alu_result_ack   = bundle_valid;
    alu_overflow_ack = bundle_valid;
    if (has_tag) begin
      alu_result_ack   = sel_result_ack   && (!alu_overflow_valid || sel_overflow_ack);
      alu_overflow_ack = sel_overflow_ack && (!alu_result_valid   || sel_result_ack);
    end
  end

  assign pop = has_tag && bundle_valid &&
               (!alu_result_valid   || alu_result_ack) &&
               (!alu_overflow_valid || alu_overflow_ack);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_served  <= REQ_B;
      tag_mem      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      illegal_op   <= 1'b0;
      stray_result <= 1'b0;
    end else begin
      illegal_op   <= illegal;
      stray_result <= bundle_valid && !has_tag;
      if (issue || illegal) last_served <= gnt_id;
      if (issue) begin
        tag_mem[wr_ptr] <= gnt_id;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (issue && !pop)      count <= count + CNT_W'(1);
      else if (pop && !issue) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
module tb_alu_request_arbiter;

  typedef struct packed {
    logic        rv;
    logic        ov;
    logic [31:0] r;
    logic [31:0] o;
  } bundle_t;

  logic clock = 1'b0;
  logic reset;

  logic        a_operator_valid, a_operator_ack, a_left_valid, a_left_ack, a_right_valid, a_right_ack;
  logic [31:0] a_operator_data, a_left_data, a_right_data;
  logic        a_result_valid, a_result_ack, a_overflow_valid, a_overflow_ack;
  logic [31:0] a_result_data, a_overflow_data;
  logic        b_operator_valid, b_operator_ack, b_left_valid, b_left_ack, b_right_valid, b_right_ack;
  logic [31:0] b_operator_data, b_left_data, b_right_data;
  logic        b_result_valid, b_result_ack, b_overflow_valid, b_overflow_ack;
  logic [31:0] b_result_data, b_overflow_data;
  logic        alu_operator_valid, alu_operator_ack, alu_left_valid, alu_left_ack, alu_right_valid, alu_right_ack;
  logic [31:0] alu_operator_data, alu_left_data, alu_right_data;
  logic        alu_result_valid, alu_result_ack, alu_overflow_valid, alu_overflow_ack;
  logic [31:0] alu_result_data, alu_overflow_data;
  logic        illegal_op, stray_result;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] qa_op[$], qa_l[$], qa_r[$], qb_op[$], qb_l[$], qb_r[$];
  bundle_t     sb_a[$], sb_b[$];
  bit          issue_log[$];
  bit          xa_o, xa_l, xa_r, xb_o, xb_l, xb_r;

  always #5 clock = ~clock;

  alu_request_arbiter dut (
    .clock(clock), .reset(reset),
    .a_operator_valid(a_operator_valid), .a_operator_data(a_operator_data), .a_operator_ack(a_operator_ack),
    .a_left_valid(a_left_valid), .a_left_data(a_left_data), .a_left_ack(a_left_ack),
    .a_right_valid(a_right_valid), .a_right_data(a_right_data), .a_right_ack(a_right_ack),
    .a_result_valid(a_result_valid), .a_result_data(a_result_data), .a_result_ack(a_result_ack),
    .a_overflow_valid(a_overflow_valid), .a_overflow_data(a_overflow_data), .a_overflow_ack(a_overflow_ack),
    .b_operator_valid(b_operator_valid), .b_operator_data(b_operator_data), .b_operator_ack(b_operator_ack),
    .b_left_valid(b_left_valid), .b_left_data(b_left_data), .b_left_ack(b_left_ack),
    .b_right_valid(b_right_valid), .b_right_data(b_right_data), .b_right_ack(b_right_ack),
    .b_result_valid(b_result_valid), .b_result_data(b_result_data), .b_result_ack(b_result_ack),
    .b_overflow_valid(b_overflow_valid), .b_overflow_data(b_overflow_data), .b_overflow_ack(b_overflow_ack),
    .alu_operator_valid(alu_operator_valid), .alu_operator_data(alu_operator_data), .alu_operator_ack(alu_operator_ack),
    .alu_left_valid(alu_left_valid), .alu_left_data(alu_left_data), .alu_left_ack(alu_left_ack),
    .alu_right_valid(alu_right_valid), .alu_right_data(alu_right_data), .alu_right_ack(alu_right_ack),
    .alu_result_valid(alu_result_valid), .alu_result_data(alu_result_data), .alu_result_ack(alu_result_ack),
    .alu_overflow_valid(alu_overflow_valid), .alu_overflow_data(alu_overflow_data), .alu_overflow_ack(alu_overflow_ack),
    .illegal_op(illegal_op), .stray_result(stray_result)
  );

  // Reference bitwise ALU: 3 SWAP, 4 NOT, 5 AND, 6 OR, others pass left.
  function automatic bundle_t alu_fn(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r);
    bundle_t b;
    b.rv = 1'b1;
    b.ov = 1'b0;
    b.o  = '0;
    case (op)
      6'd3:    begin b.r = r; b.o = l; b.ov = 1'b1; end
      6'd4:    b.r = ~l;
      6'd5:    b.r = l & r;
      6'd6:    b.r = l | r;
      default: b.r = l;
    endcase
    return b;
  endfunction

  // ALU model: one-cycle latency, 8-deep output queue, not reset by the
  // arbiter reset so in-flight results survive it.
  bundle_t alu_mem [8];
  int      alu_hd = 0, alu_tl = 0, alu_cnt = 0;
  logic    alu_take, alu_give;

  assign alu_operator_ack   = alu_operator_valid && alu_left_valid && alu_right_valid && (alu_cnt < 8);
  assign alu_left_ack       = alu_operator_ack;
  assign alu_right_ack      = alu_operator_ack;
  assign alu_result_valid   = (alu_cnt > 0) && alu_mem[alu_hd].rv;
  assign alu_overflow_valid = (alu_cnt > 0) && alu_mem[alu_hd].ov;
  assign alu_result_data    = alu_mem[alu_hd].r;
  assign alu_overflow_data  = alu_mem[alu_hd].o;
  assign alu_take = alu_operator_ack;
  assign alu_give = (alu_result_valid || alu_overflow_valid) &&
                    (!alu_result_valid || alu_result_ack) && (!alu_overflow_valid || alu_overflow_ack);

  always @(posedge clock) begin
    if (alu_take) begin
      alu_mem[alu_tl] <= alu_fn(alu_operator_data[5:0], alu_left_data, alu_right_data);
      alu_tl          <= (alu_tl + 1) % 8;
    end
    if (alu_give) alu_hd <= (alu_hd + 1) % 8;
    alu_cnt <= alu_cnt + (alu_take ? 1 : 0) - (alu_give ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: timeout, outstanding A=%0d B=%0d", tag, sb_a.size(), sb_b.size());
  endtask

  task automatic send(input bit id, input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                      input bit with_operands, input bit expect_result);
    logic [31:0] opw;
    opw = {26'h2AAAAAA, op};
    if (id == 1'b0) begin
      qa_op.push_back(opw);
      if (with_operands) begin qa_l.push_back(l); qa_r.push_back(r); end
      if (expect_result) sb_a.push_back(alu_fn(op, l, r));
    end else begin
      qb_op.push_back(opw);
      if (with_operands) begin qb_l.push_back(l); qb_r.push_back(r); end
      if (expect_result) sb_b.push_back(alu_fn(op, l, r));
    end
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(alu_operator_valid && alu_operator_ack) && n < 30);
    if (!(alu_operator_valid && alu_operator_ack)) timeout_fail(tag);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((qa_op.size() + qa_l.size() + qa_r.size() + qb_op.size() + qb_l.size() + qb_r.size() +
            sb_a.size() + sb_b.size()) != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if ((qa_op.size() + qb_op.size() + sb_a.size() + sb_b.size()) != 0) timeout_fail(tag);
    repeat (2) @(negedge clock);
  endtask

  // Source drivers: sample handshakes mid-cycle, advance queues after the edge.
  initial begin
    a_operator_valid = 0; a_left_valid = 0; a_right_valid = 0;
    b_operator_valid = 0; b_left_valid = 0; b_right_valid = 0;
    a_operator_data = '0; a_left_data = '0; a_right_data = '0;
    b_operator_data = '0; b_left_data = '0; b_right_data = '0;
    forever begin
      @(negedge clock);
      xa_o = a_operator_valid && a_operator_ack;
      xa_l = a_left_valid && a_left_ack;
      xa_r = a_right_valid && a_right_ack;
      xb_o = b_operator_valid && b_operator_ack;
      xb_l = b_left_valid && b_left_ack;
      xb_r = b_right_valid && b_right_ack;
      @(posedge clock);
      #1;
      if (xa_o) void'(qa_op.pop_front());
      if (xa_l) void'(qa_l.pop_front());
      if (xa_r) void'(qa_r.pop_front());
      if (xb_o) void'(qb_op.pop_front());
      if (xb_l) void'(qb_l.pop_front());
      if (xb_r) void'(qb_r.pop_front());
      a_operator_valid = qa_op.size() != 0; if (qa_op.size() != 0) a_operator_data = qa_op[0];
      a_left_valid     = qa_l.size()  != 0; if (qa_l.size()  != 0) a_left_data     = qa_l[0];
      a_right_valid    = qa_r.size()  != 0; if (qa_r.size()  != 0) a_right_data    = qa_r[0];
      b_operator_valid = qb_op.size() != 0; if (qb_op.size() != 0) b_operator_data = qb_op[0];
      b_left_valid     = qb_l.size()  != 0; if (qb_l.size()  != 0) b_left_data     = qb_l[0];
      b_right_valid    = qb_r.size()  != 0; if (qb_r.size()  != 0) b_right_data    = qb_r[0];
    end
  end

  // Monitor: issue order and scoreboard comparison of returned bundles.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clock);
      if (alu_operator_valid && alu_operator_ack) begin
        chk("single_grant", 32'(a_operator_ack ^ b_operator_ack), 32'd1);
        issue_log.push_back(b_operator_ack);
      end
      if ((a_result_valid || a_overflow_valid) && (!a_result_valid || a_result_ack) &&
          (!a_overflow_valid || a_overflow_ack)) begin
        if (sb_a.size() == 0) chk("a_unexpected_result", 32'(a_result_valid | a_overflow_valid), 32'd0);
        else begin
          e = sb_a.pop_front();
          chk("a_result", a_result_data, e.r);
          chk("a_overflow_valid", 32'(a_overflow_valid), 32'(e.ov));
          if (e.ov) chk("a_overflow", a_overflow_data, e.o);
          chk("a_alu_result_ack", 32'(alu_result_ack), 32'd1);
        end
      end
      if ((b_result_valid || b_overflow_valid) && (!b_result_valid || b_result_ack) &&
          (!b_overflow_valid || b_overflow_ack)) begin
        if (sb_b.size() == 0) chk("b_unexpected_result", 32'(b_result_valid | b_overflow_valid), 32'd0);
        else begin
          e = sb_b.pop_front();
          chk("b_result", b_result_data, e.r);
          chk("b_overflow_valid", 32'(b_overflow_valid), 32'(e.ov));
          if (e.ov) chk("b_overflow", b_overflow_data, e.o);
          chk("b_alu_result_ack", 32'(alu_result_ack), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int log_before;
    reset = 1'b1;
    a_result_ack = 1; a_overflow_ack = 1; b_result_ack = 1; b_overflow_ack = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_illegal_op", 32'(illegal_op), 32'd0);
    chk("rst_stray_result", 32'(stray_result), 32'd0);
    chk("rst_a_result_valid", 32'(a_result_valid | a_overflow_valid), 32'd0);
    chk("rst_b_result_valid", 32'(b_result_valid | b_overflow_valid), 32'd0);
    chk("rst_alu_acks", 32'({alu_result_ack, alu_overflow_ack}), 32'd0);
    chk("rst_alu_op_valid", 32'(alu_operator_valid), 32'd0);
    @(posedge clock); #2; reset = 1'b0;

    // Contention: A and B both stream ORs, A wins the first tie after reset.
    issue_log.delete();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 6'd6, 32'h0000_1000 * (i + 1), 32'h00A0_0000 + i, 1'b1, 1'b1);
      send(1'b1, 6'd6, 32'hB000_0000 + i, 32'h0000_0B00 << i, 1'b1, 1'b1);
    end
    wait_drain("contention_drain", 60);
    chk("cont_issue_count", issue_log.size(), 32'd8);
    for (int i = 0; i < issue_log.size() && i < 8; i++)
      chk($sformatf("cont_order_%0d", i), 32'(issue_log[i]), 32'(i % 2));

    // Single AND from A.
    send(1'b0, 6'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1);
    wait_issue("single_issue");
    chk("single_b_op_ack", 32'(b_operator_ack), 32'd0);
    @(negedge clock);
    chk("single_latency", 32'(a_result_valid), 32'd1);
    chk("single_value", a_result_data, 32'h00F0_00F0);
    chk("single_no_overflow", 32'(a_overflow_valid), 32'd0);
    chk("single_b_quiet", 32'(b_result_valid | b_overflow_valid), 32'd0);
    wait_drain("single_drain", 20);

    // SWAP from B with the overflow half held back for three cycles.
    b_overflow_ack = 1'b0;
    send(1'b1, 6'd3, 32'd1, 32'd2, 1'b1, 1'b1);
    begin
      int n = 0;
      do begin @(negedge clock); n++; end while (!b_result_valid && n < 20);
      if (!b_result_valid) timeout_fail("swap_wait");
    end
    for (int i = 0; i < 3; i++) begin
      chk("swap_result", b_result_data, 32'd2);
      chk("swap_overflow", b_overflow_data, 32'd1);
      chk("swap_both_valid", 32'({b_result_valid, b_overflow_valid}), 32'd3);
      chk("swap_held_acks", 32'({alu_result_ack, alu_overflow_ack}), 32'd0);
      chk("swap_head_kept", sb_b.size(), 32'd1);
      if (i < 2) @(negedge clock);
    end
    @(posedge clock); #2; b_overflow_ack = 1'b1;
    wait_drain("swap_drain", 20);

    // Back-pressure until the tag FIFO is full.
    issue_log.delete();
    a_result_ack = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b0, 6'd4, 32'h1000_0000 + 32'(i * 17), 32'h0, 1'b1, 1'b1);
    begin
      int n = 0;
      while (issue_log.size() < 4 && n < 30) begin @(negedge clock); n++; end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_issues", issue_log.size(), 32'd4);
      chk("bp_count", 32'(dut.count), 32'd4);
      chk("bp_no_grant", 32'({a_operator_valid, a_operator_ack, alu_operator_valid}), 32'b100);
    end
    @(posedge clock); #2; a_result_ack = 1'b1;
    @(negedge clock);
    chk("bp_pop_keeps_block", 32'(a_operator_ack), 32'd0);
    chk("bp_pop_ack", 32'(alu_result_ack), 32'd1);
    wait_drain("bp_drain", 40);
    chk("bp_total_issues", issue_log.size(), 32'd6);

    // Illegal opcode: operator swallowed, operands left for the next op.
    log_before = issue_log.size();
    send(1'b0, 6'd9, 32'hCAFE_0001, 32'h0000_0005, 1'b1, 1'b0);
    begin
      int n = 0;
      do begin @(negedge clock); n++; end while (!(a_operator_valid && a_operator_ack) && n < 20);
      if (!(a_operator_valid && a_operator_ack)) timeout_fail("illegal_wait");
    end
    chk("illegal_left_not_acked", 32'({a_left_ack, a_right_ack}), 32'd0);
    chk("illegal_alu_quiet", 32'({alu_operator_valid, alu_left_valid}), 32'd0);
    @(negedge clock);
    chk("illegal_pulse", 32'(illegal_op), 32'd1);
    chk("illegal_left_pending", 32'(a_left_valid), 32'd1);
    @(negedge clock);
    chk("illegal_pulse_end", 32'(illegal_op), 32'd0);
    chk("illegal_no_issue", issue_log.size(), 32'(log_before));
    send(1'b0, 6'd4, 32'hCAFE_0001, 32'h0000_0005, 1'b0, 1'b1);
    wait_drain("illegal_follow_drain", 20);

    // Reset in the cycle after an issue: the result returns as a stray.
    send(1'b0, 6'd4, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    wait_issue("rst_mid_issue");
    @(posedge clock); #2; reset = 1'b1; #2; reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_no_req_valid", 32'({a_result_valid, b_result_valid}), 32'd0);
    chk("rst_mid_alu_valid", 32'(alu_result_valid), 32'd1);
    chk("rst_mid_drop_ack", 32'(alu_result_ack), 32'd1);
    chk("rst_mid_stray_pre", 32'(stray_result), 32'd0);
    @(negedge clock);
    chk("stray_pulse", 32'(stray_result), 32'd1);
    chk("stray_dropped", 32'(alu_result_valid), 32'd0);
    @(negedge clock);
    chk("stray_pulse_end", 32'(stray_result), 32'd0);

    issue_log.delete();
    send(1'b0, 6'd6, 32'h0000_00AA, 32'h0000_5500, 1'b1, 1'b1);
    send(1'b1, 6'd5, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 1'b1);
    wait_drain("rst_tie_drain", 20);
    chk("rst_tie_count", issue_log.size(), 32'd2);
    if (issue_log.size() >= 2) begin
      chk("rst_tie_first_a", 32'(issue_log[0]), 32'd0);
      chk("rst_tie_second_b", 32'(issue_log[1]), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Shares one pipelined bitwise ALU between two requesters, A and B. It sits between two operator/operand stream sources and a single ALU instance. Each cycle it grants the ALU input side to one requester, chosen round-robin. It records the issuing requester in a tag FIFO and routes each returning result/overflow bundle back to that requester. It also discards illegal opcodes and stray results so that neither can deadlock the shared unit.

## Interface
- DATA_WIDTH, 32, width of operand, result and overflow data
- OPCODE_WIDTH, 6, operator.data[OPCODE_WIDTH-1:0] is the opcode
- LAST_OPCODE, 6, highest opcode the ALU accepts; larger opcodes are illegal
- TAG_DEPTH, 4, outstanding-issue FIFO depth, power of two, >= 2
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- a_operator, a_left, a_right  data_interface.consumer  DATA_WIDTH  requester A inputs
- a_result, a_overflow  data_interface.producer  DATA_WIDTH  requester A outputs
- b_operator, b_left, b_right, b_result, b_overflow  as for A, requester B
- alu_operator, alu_left, alu_right  data_interface.producer  DATA_WIDTH  to ALU inputs
- alu_result, alu_overflow  data_interface.consumer  DATA_WIDTH  from ALU outputs
- illegal_op  out  1  one-cycle pulse, an illegal operator was discarded
- stray_result  out  1  one-cycle pulse, a result arrived with no tag outstanding

## Operation
- A transfer occurs on any interface when valid && ack are high in the same cycle.
- State:
  - last_served pointer (A/B)
  - tag FIFO (1-bit entries, wr/rd pointers, count 0..TAG_DEPTH)
  - illegal_op and stray_result pulse registers
- Grant (combinational):
  - Candidates are requesters with operator.valid.
  - If both are candidates, grant the one not equal to last_served.
  - If one is a candidate, grant it.
  - If none, or the FIFO is full, there is no grant.
- Legal grant, opcode <= LAST_OPCODE:
  - Mux the granted operator, left and right valid/data onto alu_*.
  - Route alu_operator/left/right.ack back to the granted requester only.
  - The other requester's acks are 0.
- Illegal grant, opcode > LAST_OPCODE:
  - alu_operator.valid = 0.
  - Granted operator.ack = 1; left and right acks = 0, so operands are not consumed.
  - No tag is pushed. illegal_op pulses the next cycle.
  - last_served updates.
- Issue = alu_operator transfer. On issue: push the granted ID into the FIFO and set last_served to the granted ID.
- No grant: alu_* valid = 0, all requester acks = 0.
- Return path (combinational), tag = FIFO head:
  - X_result.valid = alu_result.valid && count>0 && tag==X; same rule for overflow.
  - alu_result.ack = X_result.ack && (!alu_overflow.valid || X_overflow.ack). alu_overflow.ack is symmetric.
  - Both halves of a bundle are therefore accepted in the same cycle, as the ALU requires.
- Pop the head when the bundle is accepted: (alu_result.valid || alu_overflow.valid) and each valid half acked.
- Stray result, bundle valid with count==0:
  - Ack both halves unconditionally and drop the data.
  - stray_result pulses the next cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo TAG_DEPTH.
- Reset, asynchronous, takes effect mid-operation:
  - FIFO emptied, last_served = B (A wins the first tie), pulse registers cleared.
  - In-flight ALU results then arrive as strays and are discarded.

## Timing
- Reset values:
  - illegal_op = 0, stray_result = 0.
  - All *_result/*_overflow valid = 0 (FIFO empty).
  - All acks = 0 unless the stray path is active.
- Issue path adds zero cycles. End-to-end latency is the ALU latency: issue at edge N, result visible in cycle N+1.
- Throughput: one issue per cycle when the FIFO is not full and the return path is not stalled. Alternates A/B under contention.
- Full FIFO blocks grants in that cycle. A pop in the same cycle does not unblock them (full is evaluated on the registered count).
- Pulses are registered, asserted exactly one cycle, and repeat if the event repeats.

## Test plan
- **Single op:** A sends op 5 (AND) with left 0xF0F0_F0F0, right 0x0FF0_0FF0.
  - Required: a_result = 0x00F0_00F0 one cycle after issue.
  - Required: b_* valid never asserted; a_overflow not asserted.
- **Contention:** A and B hold op 6 (OR) continuously with distinct operands, results always acked.
  - Required: issues alternate A,B,A,B starting with A.
  - Required: each result is returned only to its issuer, in order.
- **Dual output:** B sends op 3 (SWAP) with left 1, right 2.
  - Required: b_result = 2 and b_overflow = 1 in the same cycle.
  - Required: while b_overflow.ack is held 0 for 3 cycles, neither half is acked and the FIFO head is unchanged.
- **Back-pressure to full:** hold a_result.ack = 0 while A issues op 4 (NOT) repeatedly.
  - Required: while results are blocked, the FIFO fills to count 4 and no further grant is made while it is full.
  - Required: after acks resume, results drain in order with no loss.
- **Illegal opcode:** A sends opcode 9 with left valid.
  - Required: a_operator is acked, a_left is not acked.
  - Required: illegal_op pulses one cycle and nothing reaches the ALU.
  - Required: a following A NOT op on the same left value completes normally.
- **Reset mid-flight:** assert reset the cycle after an issue.
  - Required: the FIFO clears and the returning result is acked and dropped.
  - Required: stray_result pulses, no requester sees a valid result, and A wins the next tie.
